// File: rtl/div_nat_16_8_pkg.sv
// Shared constants for the 16/8 natural divider: step count, FSM encodings
// and the saturated results reported on a divide by zero.
package div_nat_16_8_pkg;

    localparam int DIV_STEPS = 16;
    localparam logic [3:0] CNT_LAST = 4'(DIV_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_WSOC = 2'd2;

    localparam logic [15:0] Q_DIV0 = 16'hFFFF;
    localparam logic [7:0]  R_DIV0 = 8'hFF;

endpackage

// File: rtl/add.sv
// Generic N-bit ripple adder with carry in and carry out.
module add #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    logic [N:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
    assign s     = sum[N-1:0];
    assign c_out = sum[N];

endmodule

// File: rtl/div_nat_16_8_step.sv
// One restoring division step: shift in the next dividend bit and subtract
// the divisor when it fits. The carry out of t - dy is the quotient bit.
module div_step (
    input  logic [7:0] rem,
    input  logic       in_bit,
    input  logic [7:0] dy,
    output logic [8:0] rem_next,
    output logic       q_bit
);

    logic [8:0] t;
    logic [8:0] diff;

    assign t = {rem, in_bit};

    add #(.N(9)) u_add (
        .a     (t),
        .b     (~{1'b0, dy}),
        .c_in  (1'b1),
        .s     (diff),
        .c_out (q_bit)
    );

    assign rem_next = q_bit ? diff : t;

endmodule

// File: rtl/div_nat_16_8.sv
// Sequential restoring divider, 16-bit dividend by 8-bit divisor, one quotient
// bit per clock, soc/eoc handshake.
//
// state  | meaning
// S_IDLE | ready, eoc=1, waiting for soc
// S_CALC | 16 restoring steps in progress
// S_WSOC | result loaded, waiting for soc to drop before re-arming
module div_nat_16_8
    import div_nat_16_8_pkg::*;
(
    input  logic        clock,
    input  logic        reset_,
    input  logic        soc,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    output logic        eoc,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        err
);

    logic [1:0]  state;
    logic [15:0] dq;
    logic [7:0]  dy;
    logic [8:0]  rem;
    logic [3:0]  cnt;
    logic [8:0]  rem_next;
    logic        q_bit;

    // The partial remainder always stays below dy, so bit 8 of rem never sets.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[8];

    div_step u_step (
        .rem      (rem[7:0]),
        .in_bit   (dq[15]),
        .dy       (dy),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_IDLE;
            eoc   <= 1'b1;
            q     <= '0;
            r     <= '0;
            err   <= 1'b0;
            dq    <= '0;
            dy    <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (soc) begin
                        dq  <= x;
                        dy  <= y;
                        rem <= '0;
                        cnt <= '0;
                        eoc <= 1'b0;
                        if (y == 8'd0) begin
                            q     <= Q_DIV0;
                            r     <= R_DIV0;
                            err   <= 1'b1;
                            state <= S_WSOC;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_next;
                    dq  <= {dq[14:0], q_bit};
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        q     <= {dq[14:0], q_bit};
                        r     <= rem_next[7:0];
                        err   <= 1'b0;
                        state <= S_WSOC;
                    end
                end
                S_WSOC: begin
                    if (!soc) begin
                        eoc   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    eoc   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
